// File: rtl/decoder_scan_ctrl.sv
// Scan controller driving a 3-to-8 decoder: steps through enabled channels
// with a fixed break-before-make blank gap, single-pass or continuous.
module decoder_scan_ctrl #(
    parameter int unsigned BLANK_CYC = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic       single,
    input  logic [7:0] ch_mask,
    input  logic [7:0] dwell,
    output logic       A,
    output logic       B,
    output logic       C,
    output logic       en,
    output logic       busy,
    output logic       ch_tick,
    output logic       wrap,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        BLANK  = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [3:0]  bcnt_q, bcnt_d;
    logic [7:0]  mask_q, mask_d;
    logic [7:0]  dwell_q, dwell_d;
    logic        single_q, single_d;
    logic        en_q, en_d;
    logic        busy_q, busy_d;
    logic        tick_q, tick_d;
    logic        wrap_q, wrap_d;
    logic        done_q, done_d;

    // {found, index} of the lowest set bit
    function automatic logic [3:0] lowest(input logic [7:0] m);
        logic [3:0] r;
        r = 4'd0;
        for (int i = 7; i >= 0; i--) begin
            if (m[i]) r = {1'b1, 3'(i)};
        end
        return r;
    endfunction

    // {found, index} of the lowest set bit strictly above cur
    function automatic logic [3:0] next_above(input logic [7:0] m,
                                              input logic [2:0] cur);
        logic [3:0] r;
        r = 4'd0;
        for (int i = 7; i >= 0; i--) begin
            if (m[i] && (i > int'(cur))) r = {1'b1, 3'(i)};
        end
        return r;
    endfunction

    logic [3:0] low_in, low_cap, nxt;

    assign low_in  = lowest(ch_mask);
    assign low_cap = lowest(mask_q);
    assign nxt     = next_above(mask_q, idx_q);

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        bcnt_d   = bcnt_q;
        mask_d   = mask_q;
        dwell_d  = dwell_q;
        single_d = single_q;
        wrap_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    mask_d   = ch_mask;
                    dwell_d  = dwell;
                    single_d = single;
                    if (low_in[3]) begin
                        state_d = ACTIVE;
                        idx_d   = low_in[2:0];
                        cnt_d   = dwell;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            ACTIVE: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (cnt_q == 8'd0) begin
                    state_d = BLANK;
                    bcnt_d  = 4'(BLANK_CYC - 1);
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            BLANK: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (bcnt_q != 4'd0) begin
                    bcnt_d = bcnt_q - 4'd1;
                end else if (nxt[3]) begin
                    state_d = ACTIVE;
                    idx_d   = nxt[2:0];
                    cnt_d   = dwell_q;
                end else if (single_q || !low_cap[3]) begin
                    state_d = DONE;
                end else begin
                    state_d = ACTIVE;
                    idx_d   = low_cap[2:0];
                    cnt_d   = dwell_q;
                    wrap_d  = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
        endcase
        // Outputs are registered from the next state
        en_d   = (state_d == ACTIVE);
        busy_d = (state_d != IDLE);
        tick_d = en_d && (cnt_d == 8'd0);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= 3'd0;
            cnt_q    <= 8'd0;
            bcnt_q   <= 4'd0;
            mask_q   <= 8'd0;
            dwell_q  <= 8'd0;
            single_q <= 1'b0;
            en_q     <= 1'b0;
            busy_q   <= 1'b0;
            tick_q   <= 1'b0;
            wrap_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            bcnt_q   <= bcnt_d;
            mask_q   <= mask_d;
            dwell_q  <= dwell_d;
            single_q <= single_d;
            en_q     <= en_d;
            busy_q   <= busy_d;
            tick_q   <= tick_d;
            wrap_q   <= wrap_d;
            done_q   <= done_d;
        end
    end

    assign A       = idx_q[2];
    assign B       = idx_q[1];
    assign C       = idx_q[0];
    assign en      = en_q;
    assign busy    = busy_q;
    assign ch_tick = tick_q;
    assign wrap    = wrap_q;
    assign done    = done_q;

endmodule

// File: tb/tb_decoder_scan_ctrl.sv
// Bench for decoder_scan_ctrl: directed vector table, hand-written corner
// sequences and randomized scans against a slot-arithmetic model.
module tb_decoder_scan_ctrl;

    localparam int BC = 1;

    logic       clk = 1'b0;
    logic       rst, start, stop, single;
    logic [7:0] ch_mask, dwell;
    logic       A, B, C, en, busy, ch_tick, wrap, done;
    logic [7:0] obs;

    int checks   = 0;
    int failures = 0;
    logic [2:0] hold_abc;

    always #5 clk = ~clk;

    decoder_scan_ctrl #(.BLANK_CYC(BC)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
        .single(single), .ch_mask(ch_mask), .dwell(dwell),
        .A(A), .B(B), .C(C), .en(en), .busy(busy),
        .ch_tick(ch_tick), .wrap(wrap), .done(done)
    );

    // {abc[2:0], en, busy, ch_tick, wrap, done}
    assign obs = {A, B, C, en, busy, ch_tick, wrap, done};

    typedef struct {
        logic       start;
        logic       stop;
        logic       single;
        logic [7:0] mask;
        logic [7:0] dwell;
        logic [7:0] exp;
    } vec_t;

    vec_t tv[20];

    task automatic check(input string name, input logic [7:0] got,
                         input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%b exp=%b at %0t", name, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Expected outputs k cycles after the start edge (k=0 is first cycle).
    function automatic logic [7:0] model(input int k, input logic [7:0] m,
                                         input logic [7:0] d, input logic s,
                                         input logic [2:0] hold);
        int ch[8];
        int n, p, slot, off;
        logic [2:0] ab;
        logic e, b, t, w, dn;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            if (m[i]) begin
                ch[n] = i;
                n++;
            end
        end
        p  = int'(d) + 1 + BC;
        ab = hold;
        e = 0; b = 0; t = 0; w = 0; dn = 0;
        if (n == 0 || (s && k >= n * p)) begin
            if (n > 0) ab = 3'(ch[n - 1]);
            if (k == n * p) begin
                b  = 1;
                dn = 1;
            end
        end else begin
            slot = k / p;
            off  = k % p;
            ab   = 3'(ch[slot % n]);
            b    = 1;
            e    = (off <= int'(d));
            t    = (off == int'(d));
            w    = !s && slot > 0 && (slot % n) == 0 && off == 0;
        end
        return {ab, e, b, t, w, dn};
    endfunction

    task automatic run_rand();
        logic [7:0] m, d, e, eL;
        logic s;
        int n, p, end_k, lim;
        bit cont;
        case ($urandom_range(0, 7))
            0:       m = 8'h00;
            1:       m = 8'(1 << $urandom_range(0, 7));
            default: m = 8'($urandom);
        endcase
        d = 8'($urandom_range(0, 4));
        s = 1'($urandom);
        n = $countones(m);
        p = int'(d) + 1 + BC;
        cont  = (!s && n > 0);
        end_k = n * p;
        lim   = cont ? $urandom_range(3, 40) : end_k + 2;
        start = 1; stop = 0; ch_mask = m; dwell = d; single = s;
        step();
        eL = 8'h00;
        for (int k = 0; k <= lim; k++) begin
            e = model(k, m, d, s, hold_abc);
            check("rand", obs, e);
            eL = e;
            ch_mask = 8'($urandom);
            dwell   = 8'($urandom);
            single  = 1'($urandom);
            start   = (cont || k <= end_k) ? 1'($urandom) : 1'b0;
            if (k < lim) step();
        end
        if (cont) begin
            start = 0;
            stop  = 1;
            step();
            check("rand_stop", obs, {eL[7:5], 5'b00000});
            stop = 0;
            step();
            check("rand_stop_idle", obs, {eL[7:5], 5'b00000});
        end else begin
            start = 0;
        end
        hold_abc = eL[7:5];
    endtask

    initial begin
        int cnt, guard;
        logic [7:0] seen;
        logic dseen;

        rst = 1; start = 0; stop = 0; single = 0;
        ch_mask = 0; dwell = 0;
        repeat (2) @(negedge clk);
        check("reset_state", obs, 8'h00);
        rst = 0;

        tv[0]  = '{1, 0, 1, 8'h05, 8'd2, 8'b000_11000};
        tv[1]  = '{0, 0, 1, 8'h05, 8'd2, 8'b000_11000};
        tv[2]  = '{0, 0, 1, 8'h05, 8'd2, 8'b000_11100};
        tv[3]  = '{0, 0, 1, 8'h05, 8'd2, 8'b000_01000};
        tv[4]  = '{0, 0, 1, 8'h05, 8'd2, 8'b010_11000};
        tv[5]  = '{0, 0, 1, 8'h05, 8'd2, 8'b010_11000};
        tv[6]  = '{0, 0, 1, 8'h05, 8'd2, 8'b010_11100};
        tv[7]  = '{0, 0, 1, 8'h05, 8'd2, 8'b010_01000};
        tv[8]  = '{0, 0, 1, 8'h05, 8'd2, 8'b010_01001};
        tv[9]  = '{0, 0, 1, 8'h05, 8'd2, 8'b010_00000};
        tv[10] = '{1, 1, 1, 8'h05, 8'd2, 8'b010_00000};
        tv[11] = '{1, 0, 1, 8'h00, 8'd2, 8'b010_01001};
        tv[12] = '{0, 0, 1, 8'h00, 8'd2, 8'b010_00000};
        tv[13] = '{1, 0, 0, 8'h80, 8'd0, 8'b111_11100};
        tv[14] = '{0, 0, 0, 8'h80, 8'd0, 8'b111_01000};
        tv[15] = '{0, 0, 0, 8'h80, 8'd0, 8'b111_11110};
        tv[16] = '{0, 0, 0, 8'h80, 8'd0, 8'b111_01000};
        tv[17] = '{0, 0, 1, 8'h0F, 8'd5, 8'b111_11110};
        tv[18] = '{0, 1, 1, 8'h0F, 8'd5, 8'b111_00000};
        tv[19] = '{0, 0, 1, 8'h0F, 8'd5, 8'b111_00000};

        for (int i = 0; i < 20; i++) begin
            start   = tv[i].start;
            stop    = tv[i].stop;
            single  = tv[i].single;
            ch_mask = tv[i].mask;
            dwell   = tv[i].dwell;
            step();
            check($sformatf("vec%0d", i), obs, tv[i].exp);
        end
        start = 0; stop = 0;

        // Abort four cycles into channel 3
        start = 1; ch_mask = 8'hFF; dwell = 8'd10; single = 0;
        step();
        start = 0;
        for (int k = 0; k < 39; k++) begin
            if (k == 36) check("abort_ch3_entry", obs, 8'b011_11000);
            step();
        end
        stop = 1;
        step();
        check("abort", obs, 8'b011_00000);
        stop = 0;
        dseen = 0;
        repeat (3) begin
            step();
            dseen |= done | busy | en;
        end
        check("abort_quiet", {7'd0, dseen}, 8'd0);

        // Mask changed mid-scan
        start = 1; ch_mask = 8'h0F; dwell = 8'd1; single = 1;
        step();
        start = 0; ch_mask = 8'hF0; single = 0;
        seen = 0; dseen = 0; guard = 0;
        while (!dseen && guard < 100) begin
            if (en) seen[{A, B, C}] = 1'b1;
            dseen = done;
            step();
            guard++;
        end
        check("mask_change_done", {7'd0, dseen}, 8'd1);
        check("mask_change_chans", seen, 8'h0F);

        // Longest dwell
        start = 1; ch_mask = 8'h01; dwell = 8'd255; single = 1;
        step();
        start = 0;
        cnt = 0; guard = 0;
        while (en && guard < 400) begin
            cnt++;
            step();
            guard++;
        end
        check("dwell255_len", 8'(cnt - 255), 8'd1);
        guard = 0;
        while (busy && guard < 10) begin
            step();
            guard++;
        end
        check("dwell255_idle", obs, 8'b000_00000);

        // Asynchronous reset mid-ACTIVE
        start = 1; ch_mask = 8'h01; dwell = 8'd255; single = 1;
        step();
        start = 0;
        repeat (5) step();
        check("pre_rst_active", obs, 8'b000_11000);
        #2 rst = 1;
        #1 check("async_rst", obs, 8'h00);
        start = 1;
        repeat (2) step();
        check("rst_hold", obs, 8'h00);
        start = 0; rst = 0;
        step();
        check("post_rst_idle", obs, 8'h00);
        hold_abc = 3'd0;

        for (int it = 0; it < 40; it++) run_rand();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

endmodule
